// File: rtl/cla_2_selftest.sv
// Self-test sequencer for the 2-bit carry-lookahead slice cla_2.
// Sweeps all 32 {a,b,c_in} vectors, checks s/g_out/p_out against a
// built-in reference and reports pass, error count and first failing index.
// A debug output exposes the FSM state so checkers can bind to it.
module cla_2_selftest #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic       c_in,
    input  logic [1:0] s,
    input  logic       g_out,
    input  logic       p_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [4:0] first_fail,
    output logic [2:0] state_dbg
);

    // Handshake: start is a single-cycle request, accepted only when the
    // state is IDLE or DONE; it is dropped (not queued) while busy is high.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  settle_q, settle_d;
    logic [1:0]  a_q, a_d, b_q, b_d;
    logic        c_q, c_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [5:0]  err_q, err_d;
    logic [4:0]  ff_q, ff_d;

    logic        g0, g1, p0, p1;
    logic [1:0]  exp_s;
    logic        exp_g, exp_p, mism;

    // Reference model of the lookahead slice, evaluated on the driven operands.
    always_comb begin
        g0    = a_q[0] & b_q[0];
        g1    = a_q[1] & b_q[1];
        p0    = a_q[0] ^ b_q[0];
        p1    = a_q[1] ^ b_q[1];
        exp_s = a_q + b_q + {1'b0, c_q};
        exp_g = g1 | (p1 & g0);
        exp_p = p1 & p0;
        mism  = (s != exp_s) | (g_out != exp_g) | (p_out != exp_p);
    end

    // Next-state and registered-output logic of the sweep sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        ff_d     = ff_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    idx_d   = 5'd0;
                    err_d   = 6'd0;
                    ff_d    = 5'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_APPLY: begin
                a_d = idx_q[4:3];
                b_d = idx_q[2:1];
                c_d = idx_q[0];
                if (SETTLE == 0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d  = ST_WAIT;
                    settle_d = 4'(SETTLE - 1);
                end
            end
            ST_WAIT: begin
                if (settle_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (mism) begin
                    err_d = err_q + 6'd1;
                    if (err_q == 6'd0) begin
                        ff_d = idx_q;
                    end
                end
                if (idx_q == 5'd31) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 6'd0);
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = ST_APPLY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset overrides any start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 5'd0;
            settle_q <= 4'd0;
            a_q      <= 2'd0;
            b_q      <= 2'd0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 6'd0;
            ff_q     <= 5'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign c_in       = c_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_cla_2_selftest.sv
// Bench for cla_2_selftest: two instances (SETTLE=1 and SETTLE=0), each
// driving its own behavioural cla_2 model with a selectable stuck-at fault.
module tb_cla_2_selftest;

    logic       clk;
    logic       rst;
    logic       start1, start0;
    int         mode;

    logic [1:0] a1, b1, s1, a0, b0, s0;
    logic       c1, g1, p1, c0, g0, p0;
    logic       busy1, done1, pass1, busy0, done0, pass0;
    logic [5:0] err1, err0;
    logic [4:0] ff1, ff0;
    logic [2:0] st1, st0;

    // muxed view of the instance under test
    int         sel;
    logic [1:0] am, bm;
    logic       cm, busym, donem, passm;
    logic [5:0] errm;
    logic [4:0] ffm;
    logic [2:0] stm;

    int n_cmp;
    int n_bad;
    logic [4:0] exp_q[$];

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural adder: plain arithmetic plus optional fault
    function automatic logic [3:0] adder(input logic [1:0] x, input logic [1:0] y,
                                         input logic ci, input int md);
        logic [2:0] sum_c, sum_n;
        logic [1:0] so;
        logic       go, po;
        sum_c = {1'b0, x} + {1'b0, y} + {2'b0, ci};
        sum_n = {1'b0, x} + {1'b0, y};
        so = sum_c[1:0];
        go = sum_n[2];
        po = ((x ^ y) == 2'b11);
        if (md == 1) so[0] = 1'b0;
        if (md == 2) go = 1'b0;
        return {so, go, po};
    endfunction

    assign {s1, g1, p1} = adder(a1, b1, c1, mode);
    assign {s0, g0, p0} = adder(a0, b0, c0, mode);

    cla_2_selftest #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c_in(c1), .s(s1), .g_out(g1), .p_out(p1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1), .state_dbg(st1)
    );

    cla_2_selftest #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .a(a0), .b(b0), .c_in(c0), .s(s0), .g_out(g0), .p_out(p0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail(ff0), .state_dbg(st0)
    );

    always_comb begin
        if (sel == 1) begin
            am = a1; bm = b1; cm = c1; busym = busy1; donem = done1;
            passm = pass1; errm = err1; ffm = ff1; stm = st1;
        end else begin
            am = a0; bm = b0; cm = c0; busym = busy0; donem = done0;
            passm = pass0; errm = err0; ffm = ff0; stm = st0;
        end
    end

    // expected error count / first fail from the spec reference equations
    task automatic expect_errors(input int md, output int ec, output int fi);
        logic [1:0] x, y, rs;
        logic ci, rg, rp;
        logic [3:0] got;
        ec = 0;
        fi = 0;
        for (int i = 0; i < 32; i++) begin
            x  = 2'(i >> 3);
            y  = 2'(i >> 1);
            ci = i[0];
            rs = x + y + {1'b0, ci};
            rg = (x[1] & y[1]) | ((x[1] ^ y[1]) & (x[0] & y[0]));
            rp = (x[1] ^ y[1]) & (x[0] ^ y[0]);
            got = adder(x, y, ci, md);
            if (got != {rs, rg, rp}) begin
                if (ec == 0) fi = i;
                ec++;
            end
        end
    endtask

    // full sweep on the selected instance with cycle-exact checking
    task automatic run_sweep(input int st, input int md, input int repulse_at);
        int period, total, ec, fi, phase;
        logic [2:0] exp_st;
        logic [4:0] e;
        sel    = st;
        mode   = md;
        period = st + 2;
        total  = 32 * period;
        expect_errors(md, ec, fi);
        exp_q.delete();
        for (int n = 1; n <= total; n++) exp_q.push_back(5'((n - 1) / period));
        @(negedge clk);
        if (st == 1) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start0 = 1'b0;
        n_cmp++;
        if (busym !== 1'b1 || stm !== 3'd1) begin
            n_bad++;
            $display("FAIL start_accept: busy=%0b state=%0d, want busy=1 state=1", busym, stm);
        end
        for (int n = 1; n <= total; n++) begin
            if (n == repulse_at + 1) begin start1 = 1'b0; start0 = 1'b0; end
            @(posedge clk); #1;
            if (n == repulse_at) begin
                if (st == 1) start1 = 1'b1; else start0 = 1'b1;
            end
            e = exp_q.pop_front();
            phase = n % period;
            if (n == total) exp_st = 3'd4;
            else if (phase == 0) exp_st = 3'd1;
            else if (phase == period - 1) exp_st = 3'd3;
            else exp_st = 3'd2;
            n_cmp++;
            if ({am, bm, cm} !== e || stm !== exp_st) begin
                n_bad++;
                $display("FAIL sweep_cycle%0d: op=%0d state=%0d, want op=%0d state=%0d",
                         n, {am, bm, cm}, stm, e, exp_st);
            end
            n_cmp++;
            if (busym !== (n != total) || donem !== (n == total)) begin
                n_bad++;
                $display("FAIL busy_done_cycle%0d: busy=%0b done=%0b", n, busym, donem);
            end
            if (n == 1) begin
                n_cmp++;
                if (errm !== 6'd0) begin
                    n_bad++;
                    $display("FAIL err_clear: err_count=%0d, want 0", errm);
                end
            end
        end
        n_cmp++;
        if (errm !== 6'(ec) || passm !== (ec == 0) || (ec != 0 && ffm !== 5'(fi))) begin
            n_bad++;
            $display("FAIL result_mode%0d: err=%0d ff=%0d pass=%0b, want err=%0d ff=%0d pass=%0b",
                     md, errm, ffm, passm, ec, fi, (ec == 0));
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (st1 !== 3'd0 || {a1, b1, c1} !== 5'd0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
            pass1 !== 1'b0 || err1 !== 6'd0 || ff1 !== 5'd0 || st0 !== 3'd0 || busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: st=%0d op=%0d busy=%0b done=%0b pass=%0b err=%0d, want all 0",
                     st1, {a1, b1, c1}, busy1, done1, pass1, err1);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (st1 !== 3'd0) begin
            n_bad++;
            $display("FAIL rst_start_same_edge: state=%0d, want 0", st1);
        end
    endtask

    task automatic test_mid_reset();
        sel = 1; mode = 0;
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        repeat (31) begin @(posedge clk); #1; end
        n_cmp++;
        if (st1 !== 3'd2 || {a1, b1, c1} !== 5'd10) begin
            n_bad++;
            $display("FAIL pre_abort: state=%0d op=%0d, want state=2 op=10", st1, {a1, b1, c1});
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        n_cmp++;
        if (st1 !== 3'd0 || {a1, b1, c1} !== 5'd0 || busy1 !== 1'b0 || err1 !== 6'd0 || done1 !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: st=%0d op=%0d busy=%0b err=%0d, want 0", st1, {a1, b1, c1}, busy1, err1);
        end
        run_sweep(1, 0, 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; start1 = 1'b0; start0 = 1'b0; mode = 0; sel = 1;
        test_reset();
        run_sweep(1, 0, 0);     // correct adder, SETTLE=1
        run_sweep(1, 1, 0);     // s[0] stuck at 0
        run_sweep(1, 2, 0);     // g_out stuck at 0
        run_sweep(0, 0, 0);     // SETTLE=0
        run_sweep(0, 1, 0);
        test_mid_reset();
        run_sweep(1, 0, 40);    // start re-pulsed mid-sweep
        run_sweep(1, 2, 0);     // failing run, then restart from DONE
        run_sweep(1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_2_selftest.md
# cla_2_selftest

On-board self-test sequencer for the 2-bit carry-lookahead slice `cla_2`, used on the sum board. It drives the adder's operand inputs `a`, `b` and `c_in`, and reads back its `s`, `g_out` and `p_out`. It sweeps all 32 operand combinations, compares each response against an internal reference model, and reports pass/fail, an error count and the first failing vector.

## Interface
- SETTLE, default 1: idle cycles between driving operands and sampling results; legal range 0–15.
- clk  in  1  system clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- a  out  2  operand A to the adder, registered.
- b  out  2  operand B to the adder, registered.
- c_in  out  1  carry-in to the adder, registered.
- s  in  2  adder sum.
- g_out  in  1  adder group generate.
- p_out  in  1  adder group propagate.
- busy  out  1  high in APPLY, WAIT and CHECK.
- done  out  1  high in DONE.
- pass  out  1  equals done AND err_count==0.
- err_count  out  6  number of mismatching vectors, 0–32.
- first_fail  out  5  index of the first mismatching vector; meaningful only when err_count>0.

## Operation
- Vector index idx[4:0] encodes {a[1:0], b[1:0], c_in}.
  - idx 0: a=0, b=0, c_in=0.
  - idx 31: a=3, b=3, c_in=1.
- Reference model, per bit i:
  - gi = ai & bi
  - pi = ai ^ bi
  - exp_s = (a + b + c_in) mod 4
  - exp_g = g1 | (p1 & g0)
  - exp_p = p1 & p0
- A vector mismatches if any of s, g_out or p_out differs from the model.
- States and transitions:
  - IDLE: start goes to APPLY; idx, err_count and first_fail are cleared.
  - APPLY (1 cycle): registers a, b, c_in from idx. Goes to WAIT, or straight to CHECK if SETTLE=0.
  - WAIT (SETTLE cycles): a settle counter counts down; the operands are held.
  - CHECK (1 cycle): compares the adder response with the model.
    - On mismatch: err_count increments. If err_count was 0, first_fail loads idx.
    - If idx==31, go to DONE; otherwise idx increments and the state returns to APPLY.
  - DONE: holds results and the last operands. start goes to APPLY with a full clear, the same as from IDLE.
- start is ignored while busy. It is not queued.
- err_count cannot overflow: at most 32 errors, in 6 bits.
- Reset values: state IDLE, a=0, b=0, c_in=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, idx=0, settle counter 0.
- Reset asserted mid-sweep aborts the sweep immediately on that edge. All outputs take their reset values and there is no partial result.
- rst and start high on the same edge: rst wins and start is discarded.

## Timing
- Let edge k be the edge at which start is sampled in IDLE or DONE.
  - busy=1 from after edge k.
  - The first operands appear on a, b, c_in after edge k+1.
- Each vector takes SETTLE+2 cycles.
  - The adder has SETTLE+1 cycles of settling before it is sampled.
- The last CHECK occurs at edge k+32·(SETTLE+2).
  - done=1 and busy=0 after that edge.
  - With default SETTLE=1 this is 96 cycles after start.
- err_count and first_fail update on the CHECK edge and are visible the cycle after.
- s, g_out and p_out are sampled combinationally at the CHECK edge only.
  - Changes on them in any other state have no effect.

## Test plan
- Correct behavioural adder, SETTLE=1, start pulse:
  - done rises 96 cycles after start.
  - pass=1, err_count=0.
  - a, b, c_in walk idx 0→31, each held 3 cycles.
- Adder with s[0] stuck at 0:
  - err_count=16, first_fail=1 (a=0, b=0, c_in=1), pass=0.
- Adder with g_out stuck at 0:
  - err_count=12, first_fail=14 (a=1, b=3, c_in=0), pass=0.
- Correct adder, SETTLE=0:
  - done 64 cycles after start.
  - CHECK directly follows APPLY.
  - pass=1.
- rst pulsed while idx=10 in WAIT:
  - Next cycle: IDLE, a=b=c_in=0, busy=0, err_count=0.
  - A new start gives a full, correct 96-cycle sweep.
- start re-pulsed mid-sweep is ignored and the schedule is unchanged.
- Restart from DONE after a failing run, with a correct adder:
  - err_count clears on restart.
  - pass=1 at the end.
